// File: rtl/sorted_pair_bsg.sv
// sorted_pair_bsg: two unary bitstreams from two operands, both compared against one bit-reversed period counter
//   clk, rst_n (async, active low) | start, stop | src0, src1 [WIDTH]
//   out[1:0] streams, valid, busy (RUN/DONE), done (1-cycle pulse), swapped
//   SORTED_PAIR_BSG_SORT_EN: latch the larger operand into op1 so out[1] dominates out[0]
module sorted_pair_bsg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    output logic [1:0]       out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             swapped
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] cnt, op0, op1, rng;
    logic swap;
`ifdef SORTED_PAIR_BSG_SORT_EN
    assign swap = src0 > src1;
`else
    assign swap = 1'b0;
`endif
    always_comb begin
        rng = '0;
        for (int i = 0; i < WIDTH; i++) rng[i] = cnt[WIDTH-1-i];
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (stop ? IDLE : (&cnt ? DONE : RUN)) : IDLE;
        valid = state == RUN;
        busy  = state != IDLE;
        done  = state == DONE;
        out   = {valid & (op1 > rng), valid & (op0 > rng)};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op0     <= '0;
            op1     <= '0;
            swapped <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op0     <= swap ? src1 : src0;
                op1     <= swap ? src0 : src1;
                swapped <= swap;
                cnt     <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_sorted_pair_bsg.sv
// tb_sorted_pair_bsg: scoreboard bench for sorted_pair_bsg at WIDTH=8
module tb_sorted_pair_bsg;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] src0 = '0, src1 = '0;
    logic [1:0] out;
    logic valid, busy, done, swapped;
    logic [2:0] q[$];
    logic [2:0] e;
    int n_cmp = 0, n_bad = 0, ones0 = 0, ones1 = 0;

    sorted_pair_bsg #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .src0(src0), .src1(src1), .out(out), .valid(valid),
        .busy(busy), .done(done), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid || done) begin
            chk("busy", {31'd0, busy}, 32'd1);
            if (q.size() == 0) chk("extra", {30'd0, done, valid}, 32'd0);
            else begin
                e = q.pop_front();
                chk("stream", {29'd0, done, out}, {29'd0, e});
            end
            ones0 += int'(out[0]);
            ones1 += int'(out[1]);
        end
    end

    // kind: 0 full period, 1 stop at RUN cycle ab_at, 2 reset at RUN cycle ab_at
    task automatic run(input logic [7:0] a, input logic [7:0] b, input int ab_at, input int kind, input bit hold);
        logic [7:0] lo, hi, r;
        logic sw;
        int n;
        lo = a; hi = b; sw = 1'b0;
`ifdef SORTED_PAIR_BSG_SORT_EN
        if (a > b) begin lo = b; hi = a; sw = 1'b1; end
`endif
        n = kind == 0 ? 256 : ab_at + 1;
        for (int k = 0; k < n; k++) begin
            r = bitrev(k[7:0]);
            q.push_back({1'b0, hi > r, lo > r});
        end
        if (kind == 0) q.push_back(3'b100);
        @(negedge clk);
        ones0 = 0; ones1 = 0;
        src0 = a; src1 = b; start = 1'b1;
        for (int j = 1; j <= 262; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (!hold) start = 1'b0;
                src0 = ~a; src1 = ~b;
                chk("swapped", {31'd0, swapped}, {31'd0, sw});
            end
            if (hold && j == 257) start = 1'b0;
            if (kind == 1) stop = (j == ab_at + 1);
            if (kind == 2 && j == ab_at + 1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_outs", {27'd0, out, valid, busy, done, swapped}, 32'd0);
            end
            if (kind == 2 && j == ab_at + 2) rst_n = 1'b1;
        end
        chk("drain", q.size(), 32'd0);
        chk("idle_after", {29'd0, valid, busy, done}, 32'd0);
        if (kind == 0) begin
            chk("ones0", ones0, {24'd0, lo});
            chk("ones1", ones1, {24'd0, hi});
        end
        q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset", {27'd0, out, valid, busy, done, swapped}, 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle", {27'd0, out, valid, busy, done, swapped}, 32'd0);
        end
        run(8'd64, 8'd192, 0, 0, 1'b0);
        run(8'd200, 8'd10, 0, 0, 1'b1);
        run(8'd0, 8'd255, 0, 0, 1'b0);
        run(8'd255, 8'd0, 0, 0, 1'b0);
        run(8'd77, 8'd77, 0, 0, 1'b0);
        run(8'd10, 8'd20, 100, 1, 1'b0);
        run(8'd33, 8'd99, 0, 0, 1'b0);
        run(8'd123, 8'd45, 50, 2, 1'b0);
        run(8'd5, 8'd250, 0, 0, 1'b0);
        run(8'd1, 8'd128, 0, 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
